instr_decoder_pipe: RTL and testbench
=====================================

INSTR_DECODER_PIPE -- requirements
Module: instr_decoder_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning instruction/immediate word width (opcode = top 8 bits).
REQ-002 SHALL have parameter REG_SEL_W, default 3, meaning register-select width.
REQ-003 SHALL have parameter SP_SEL, default 7 (all ones), meaning register index substituted as rS for PUSH/POP/PUSHI.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have flush, input, 1, synchronous discard of partial and pending decode.
REQ-008 SHALL have in_word, input, DATA_W, fetched instruction or immediate word.
REQ-009 SHALL have in_valid / in_ready, input / output, 1 each, fetch handshake.
REQ-010 SHALL have dec_valid / dec_ready, output / input, 1 each, decode-result handshake.
REQ-011 SHALL have alu_control, output, 8, ALU op code.
REQ-012 SHALL have rD_sel and rS_sel, output, REG_SEL_W each, destination and source selects.
REQ-013 SHALL have immediate, output, DATA_W; en_immediate, output, 1.
REQ-014 SHALL have en_mem, mem_byte, mem_displacement, lr_is_input, output, 1 each; condition, output, 4.
REQ-015 SHALL have insn_len, output, 2, words consumed by the decoded instruction (1 or 2).

Function
REQ-016 SHALL accept a word only when in_valid && in_ready; in_ready = !dec_valid || dec_ready, forced 0 while flush=1.
REQ-017 SHALL implement FSM states S_OP (expect opcode word) and S_IMM (expect immediate word).
REQ-018 S_OP, accepted word with bit DATA_W-1 = 1: latch decoded fields into holding registers, go S_IMM, dec_valid unchanged by this word.
REQ-019 S_OP, accepted word with bit DATA_W-1 = 0: load outputs, dec_valid=1 next cycle, insn_len=1, stay S_OP.
REQ-020 S_IMM, accepted word: immediate=in_word, en_immediate=1, insn_len=2, outputs from holding registers, dec_valid=1 next cycle, go S_OP.
REQ-021 MOVB_R0..R7 opcodes: alu_control=OPC_MOV, rD_sel=opcode-OPC_MOVB_R0, immediate=zero-extended low byte, en_immediate=1, insn_len=1.
REQ-022 Other opcodes: alu_control={0,opcode[6:0]}, rD_sel=word[2:0], rS_sel=word[5:3] except SP_SEL for PUSH/POP/PUSHI; single-word immediate=0, en_immediate=0.
REQ-023 en_mem=1 and mem_byte=word[7] for ST/LD/LDI/STI/PUSH/PUSHI/POP, else both 0.
REQ-024 mem_displacement=word[6] for LDI/STI, else 0; lr_is_input=1 only for SPEC.
REQ-025 condition=word[6:3] for JMP/JMPI/SET/CALL/CALLI, else 0.
REQ-026 While dec_valid=1 && dec_ready=0, all decode outputs SHALL hold stable.
REQ-027 Result consumed (dec_valid && dec_ready) with no new completion that cycle: dec_valid=0 next cycle; with completion: new result loads, dec_valid stays 1 (back-to-back, one instruction/cycle for single-word).
REQ-028 flush=1: next cycle state=S_OP, dec_valid=0, holding registers invalidated; flush wins over simultaneous acceptance or completion.

Reset
REQ-029 rst_n=0 SHALL immediately force state=S_OP, dec_valid=0, all decode outputs 0, insn_len=0, regardless of state (including mid S_IMM).
REQ-030 First word accepted after reset release SHALL be decoded as an opcode.

Verification
REQ-031 {OPC_ADD,8'h2B} accepted -> next cycle dec_valid=1, alu_control=OPC_ADD, rD_sel=3, rS_sel=5, en_immediate=0, insn_len=1.
REQ-032 {OPC_MOVB_R4,8'hA5} -> rD_sel=4, immediate=16'h00A5, en_immediate=1, alu_control=OPC_MOV, insn_len=1.
REQ-033 {OPC_ADD|8'h80,8'h2B} then 16'h1234 -> no dec_valid after word 1; after word 2 immediate=16'h1234, en_immediate=1, rD_sel=3, rS_sel=5, insn_len=2.
REQ-034 dec_ready=0 for 3 cycles with result pending and in_valid=1 -> in_ready=0, outputs unchanged, no word lost; dec_ready=1 -> next word accepted that cycle.
REQ-035 flush in S_IMM, then 16'h0000-class word {OPC_ADD,8'h2B} -> decoded as opcode (rD_sel=3), not as immediate.
REQ-036 rst_n=0 in S_IMM with dec_valid=1 -> dec_valid=0 and outputs 0 without clock edge; after release {OPC_PUSH,8'h81} -> rS_sel=7, en_mem=1, mem_byte=1.

Source files
------------

// File: rtl/instr_decoder_pipe.sv
// instr_decoder_pipe: one-or-two word instruction decoder with a registered
// result stage and valid/ready handshakes on both sides.
//
// Ports
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   flush              synchronous discard of a half-decoded or pending result
//   in_word/in_valid/in_ready   fetch side (opcode or immediate word)
//   dec_valid/dec_ready        decode-result side
//   alu_control, rD_sel, rS_sel, immediate, en_immediate, en_mem, mem_byte,
//   mem_displacement, lr_is_input, condition, insn_len   decoded fields
//
// Word layout: opcode = in_word[DATA_W-1 -: 8]; bit DATA_W-1 set means the
// instruction carries a second (immediate) word. Operand fields live in the
// low byte.

package instr_decoder_pipe_pkg;
  localparam logic [7:0] OPC_NOP     = 8'h00;
  localparam logic [7:0] OPC_ADD     = 8'h01;
  localparam logic [7:0] OPC_SUB     = 8'h02;
  localparam logic [7:0] OPC_AND     = 8'h03;
  localparam logic [7:0] OPC_OR      = 8'h04;
  localparam logic [7:0] OPC_XOR     = 8'h05;
  localparam logic [7:0] OPC_MOV     = 8'h06;
  localparam logic [7:0] OPC_CMP     = 8'h07;
  localparam logic [7:0] OPC_ST      = 8'h10;
  localparam logic [7:0] OPC_LD      = 8'h11;
  localparam logic [7:0] OPC_LDI     = 8'h12;
  localparam logic [7:0] OPC_STI     = 8'h13;
  localparam logic [7:0] OPC_PUSH    = 8'h14;
  localparam logic [7:0] OPC_PUSHI   = 8'h15;
  localparam logic [7:0] OPC_POP     = 8'h16;
  localparam logic [7:0] OPC_JMP     = 8'h20;
  localparam logic [7:0] OPC_JMPI    = 8'h21;
  localparam logic [7:0] OPC_SET     = 8'h22;
  localparam logic [7:0] OPC_CALL    = 8'h23;
  localparam logic [7:0] OPC_CALLI   = 8'h24;
  localparam logic [7:0] OPC_SPEC    = 8'h30;
  // MOVB_R0..MOVB_R7 occupy the aligned block 8'h38..8'h3F
  localparam logic [7:0] OPC_MOVB_R0 = 8'h38;
endpackage

module instr_decoder_pipe
  import instr_decoder_pipe_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned REG_SEL_W = 3,
  parameter int unsigned SP_SEL    = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [DATA_W-1:0]    in_word,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 dec_valid,
  input  logic                 dec_ready,
  output logic [7:0]           alu_control,
  output logic [REG_SEL_W-1:0] rD_sel,
  output logic [REG_SEL_W-1:0] rS_sel,
  output logic [DATA_W-1:0]    immediate,
  output logic                 en_immediate,
  output logic                 en_mem,
  output logic                 mem_byte,
  output logic                 mem_displacement,
  output logic                 lr_is_input,
  output logic [3:0]           condition,
  output logic [1:0]           insn_len
);

  typedef enum logic {S_OP = 1'b0, S_IMM = 1'b1} state_e;

  state_e state_q, state_d;

  // Result registers
  logic                 dec_valid_q, dec_valid_d;
  logic [7:0]           alu_q, alu_d;
  logic [REG_SEL_W-1:0] rd_q, rd_d;
  logic [REG_SEL_W-1:0] rs_q, rs_d;
  logic [DATA_W-1:0]    imm_q, imm_d;
  logic                 en_imm_q, en_imm_d;
  logic                 en_mem_q, en_mem_d;
  logic                 mem_byte_q, mem_byte_d;
  logic                 disp_q, disp_d;
  logic                 lr_q, lr_d;
  logic [3:0]           cond_q, cond_d;
  logic [1:0]           len_q, len_d;

  // Holding registers for the opcode word of a two-word instruction
  logic [7:0]           h_alu_q, h_alu_d;
  logic [REG_SEL_W-1:0] h_rd_q, h_rd_d;
  logic [REG_SEL_W-1:0] h_rs_q, h_rs_d;
  logic                 h_en_mem_q, h_en_mem_d;
  logic                 h_mem_byte_q, h_mem_byte_d;
  logic                 h_disp_q, h_disp_d;
  logic                 h_lr_q, h_lr_d;
  logic [3:0]           h_cond_q, h_cond_d;

  // Combinational decode of in_word as an opcode word
  logic [6:0]           base;
  logic [7:0]           lo;
  logic                 two_word;
  logic                 is_movb, is_stack, is_mem, is_disp, is_branch;
  logic [7:0]           dc_alu;
  logic [REG_SEL_W-1:0] dc_rd, dc_rs;
  logic [DATA_W-1:0]    dc_imm;
  logic                 dc_en_imm, dc_en_mem, dc_mem_byte, dc_disp, dc_lr;
  logic [3:0]           dc_cond;
  logic                 accept;

  // Consumer free (or about to be) and no flush in progress
  assign in_ready = !flush && (!dec_valid_q || dec_ready);
  assign accept   = in_valid && in_ready;

  // Opcode-word field decode; bit 7 of the opcode only selects the word count
  always_comb begin
    base      = in_word[DATA_W-2 -: 7];
    lo        = in_word[7:0];
    two_word  = in_word[DATA_W-1];
    is_movb   = (base[6:3] == OPC_MOVB_R0[6:3]);
    is_stack  = base inside {OPC_PUSH[6:0], OPC_POP[6:0], OPC_PUSHI[6:0]};
    is_mem    = base inside {OPC_ST[6:0], OPC_LD[6:0], OPC_LDI[6:0], OPC_STI[6:0],
                             OPC_PUSH[6:0], OPC_PUSHI[6:0], OPC_POP[6:0]};
    is_disp   = base inside {OPC_LDI[6:0], OPC_STI[6:0]};
    is_branch = base inside {OPC_JMP[6:0], OPC_JMPI[6:0], OPC_SET[6:0],
                             OPC_CALL[6:0], OPC_CALLI[6:0]};

    dc_alu      = {1'b0, base};
    dc_rd       = REG_SEL_W'(lo[2:0]);
    dc_rs       = is_stack ? REG_SEL_W'(SP_SEL) : REG_SEL_W'(lo[5:3]);
    dc_imm      = '0;
    dc_en_imm   = 1'b0;
    dc_en_mem   = is_mem;
    dc_mem_byte = is_mem && lo[7];
    dc_disp     = is_disp && lo[6];
    dc_lr       = (base == OPC_SPEC[6:0]);
    dc_cond     = is_branch ? lo[6:3] : 4'd0;

    // Move-byte: destination register is encoded in the opcode itself
    if (is_movb) begin
      dc_alu    = OPC_MOV;
      dc_rd     = REG_SEL_W'(base[2:0]);
      dc_rs     = '0;
      dc_imm    = DATA_W'(lo);
      dc_en_imm = 1'b1;
    end
  end

  // Next-state, result and holding register update
  always_comb begin
    state_d      = state_q;
    dec_valid_d  = dec_valid_q;
    alu_d        = alu_q;
    rd_d         = rd_q;
    rs_d         = rs_q;
    imm_d        = imm_q;
    en_imm_d     = en_imm_q;
    en_mem_d     = en_mem_q;
    mem_byte_d   = mem_byte_q;
    disp_d       = disp_q;
    lr_d         = lr_q;
    cond_d       = cond_q;
    len_d        = len_q;
    h_alu_d      = h_alu_q;
    h_rd_d       = h_rd_q;
    h_rs_d       = h_rs_q;
    h_en_mem_d   = h_en_mem_q;
    h_mem_byte_d = h_mem_byte_q;
    h_disp_d     = h_disp_q;
    h_lr_d       = h_lr_q;
    h_cond_d     = h_cond_q;

    if (flush) begin
      // in_ready is low here, so no word can be accepted alongside a flush
      state_d      = S_OP;
      dec_valid_d  = 1'b0;
      h_alu_d      = '0;
      h_rd_d       = '0;
      h_rs_d       = '0;
      h_en_mem_d   = 1'b0;
      h_mem_byte_d = 1'b0;
      h_disp_d     = 1'b0;
      h_lr_d       = 1'b0;
      h_cond_d     = '0;
    end else begin
      if (dec_valid_q && dec_ready) begin
        dec_valid_d = 1'b0;
      end
      if (accept) begin
        unique case (state_q)
          S_OP: begin
            if (two_word) begin
              h_alu_d      = dc_alu;
              h_rd_d       = dc_rd;
              h_rs_d       = dc_rs;
              h_en_mem_d   = dc_en_mem;
              h_mem_byte_d = dc_mem_byte;
              h_disp_d     = dc_disp;
              h_lr_d       = dc_lr;
              h_cond_d     = dc_cond;
              state_d      = S_IMM;
            end else begin
              alu_d       = dc_alu;
              rd_d        = dc_rd;
              rs_d        = dc_rs;
              imm_d       = dc_imm;
              en_imm_d    = dc_en_imm;
              en_mem_d    = dc_en_mem;
              mem_byte_d  = dc_mem_byte;
              disp_d      = dc_disp;
              lr_d        = dc_lr;
              cond_d      = dc_cond;
              len_d       = 2'd1;
              dec_valid_d = 1'b1;
            end
          end
          S_IMM: begin
            alu_d       = h_alu_q;
            rd_d        = h_rd_q;
            rs_d        = h_rs_q;
            imm_d       = in_word;
            en_imm_d    = 1'b1;
            en_mem_d    = h_en_mem_q;
            mem_byte_d  = h_mem_byte_q;
            disp_d      = h_disp_q;
            lr_d        = h_lr_q;
            cond_d      = h_cond_q;
            len_d       = 2'd2;
            dec_valid_d = 1'b1;
            state_d     = S_OP;
          end
          default: state_d = S_OP;
        endcase
      end
    end
  end

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_OP;
      dec_valid_q  <= 1'b0;
      alu_q        <= '0;
      rd_q         <= '0;
      rs_q         <= '0;
      imm_q        <= '0;
      en_imm_q     <= 1'b0;
      en_mem_q     <= 1'b0;
      mem_byte_q   <= 1'b0;
      disp_q       <= 1'b0;
      lr_q         <= 1'b0;
      cond_q       <= '0;
      len_q        <= '0;
      h_alu_q      <= '0;
      h_rd_q       <= '0;
      h_rs_q       <= '0;
      h_en_mem_q   <= 1'b0;
      h_mem_byte_q <= 1'b0;
      h_disp_q     <= 1'b0;
      h_lr_q       <= 1'b0;
      h_cond_q     <= '0;
    end else begin
      state_q      <= state_d;
      dec_valid_q  <= dec_valid_d;
      alu_q        <= alu_d;
      rd_q         <= rd_d;
      rs_q         <= rs_d;
      imm_q        <= imm_d;
      en_imm_q     <= en_imm_d;
      en_mem_q     <= en_mem_d;
      mem_byte_q   <= mem_byte_d;
      disp_q       <= disp_d;
      lr_q         <= lr_d;
      cond_q       <= cond_d;
      len_q        <= len_d;
      h_alu_q      <= h_alu_d;
      h_rd_q       <= h_rd_d;
      h_rs_q       <= h_rs_d;
      h_en_mem_q   <= h_en_mem_d;
      h_mem_byte_q <= h_mem_byte_d;
      h_disp_q     <= h_disp_d;
      h_lr_q       <= h_lr_d;
      h_cond_q     <= h_cond_d;
    end
  end

  assign dec_valid        = dec_valid_q;
  assign alu_control      = alu_q;
  assign rD_sel           = rd_q;
  assign rS_sel           = rs_q;
  assign immediate        = imm_q;
  assign en_immediate     = en_imm_q;
  assign en_mem           = en_mem_q;
  assign mem_byte         = mem_byte_q;
  assign mem_displacement = disp_q;
  assign lr_is_input      = lr_q;
  assign condition        = cond_q;
  assign insn_len         = len_q;

endmodule

// File: tb/tb_instr_decoder_pipe.sv
// Bench for instr_decoder_pipe: directed vectors with literal expectations,
// plus an instruction-level reference model checked every falling edge.
module tb_instr_decoder_pipe;

  localparam logic [7:0] ADD = 8'h01, SUB = 8'h02, XOR = 8'h05, MOV = 8'h06;
  localparam logic [7:0] ST = 8'h10, LD = 8'h11, LDI = 8'h12, STI = 8'h13;
  localparam logic [7:0] PUSH = 8'h14, PUSHI = 8'h15, POP = 8'h16;
  localparam logic [7:0] JMP = 8'h20, JMPI = 8'h21, SET = 8'h22, CALL = 8'h23, CALLI = 8'h24;
  localparam logic [7:0] SPEC = 8'h30, MOVB_R4 = 8'h3C;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, dec_valid, dec_ready;
  logic [15:0] in_word, immediate;
  logic [7:0]  alu_control;
  logic [2:0]  rD_sel, rS_sel;
  logic        en_immediate, en_mem, mem_byte, mem_displacement, lr_is_input;
  logic [3:0]  condition;
  logic [1:0]  insn_len;

  instr_decoder_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_word(in_word),
    .in_valid(in_valid), .in_ready(in_ready), .dec_valid(dec_valid),
    .dec_ready(dec_ready), .alu_control(alu_control), .rD_sel(rD_sel),
    .rS_sel(rS_sel), .immediate(immediate), .en_immediate(en_immediate),
    .en_mem(en_mem), .mem_byte(mem_byte), .mem_displacement(mem_displacement),
    .lr_is_input(lr_is_input), .condition(condition), .insn_len(insn_len)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct packed {
    logic [7:0]  alu;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [15:0] imm;
    logic        en_imm;
    logic        en_mem;
    logic        mem_byte;
    logic        disp;
    logic        lr;
    logic [3:0]  cond;
    logic [1:0]  len;
  } res_t;

  res_t act;
  assign act = {alu_control, rD_sel, rS_sel, immediate, en_immediate, en_mem,
                mem_byte, mem_displacement, lr_is_input, condition, insn_len};

  // What an instruction means, from its opcode word and optional immediate
  function automatic res_t model_decode(input logic [15:0] opw, input logic [15:0] immw,
                                        input bit two);
    res_t r;
    logic [7:0] opc, lo;
    r   = '0;
    opc = {1'b0, opw[14:8]};
    lo  = opw[7:0];
    r.len = two ? 2'd2 : 2'd1;
    if (opc >= 8'h38 && opc <= 8'h3F) begin
      r.alu    = MOV;
      r.rd     = 3'(opc - 8'h38);
      r.imm    = two ? immw : 16'(lo);
      r.en_imm = 1'b1;
    end else begin
      r.alu    = opc;
      r.rd     = 3'(lo % 8'd8);
      r.rs     = (opc == PUSH || opc == POP || opc == PUSHI) ? 3'd7 : 3'((lo / 8'd8) % 8'd8);
      r.imm    = two ? immw : 16'd0;
      r.en_imm = two;
    end
    if (opc inside {ST, LD, LDI, STI, PUSH, PUSHI, POP}) begin
      r.en_mem   = 1'b1;
      r.mem_byte = (lo >= 8'd128);
    end
    if (opc == LDI || opc == STI) r.disp = ((lo / 8'd64) % 8'd2) != 8'd0;
    r.lr = (opc == SPEC);
    if (opc inside {JMP, JMPI, SET, CALL, CALLI}) r.cond = 4'((lo / 8'd8) % 8'd16);
    return r;
  endfunction

  // Reference: pending result, and whether an opcode word awaits its immediate
  res_t        m_out;
  bit          m_valid, m_wait_imm, m_acc;
  logic [15:0] m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out = '0; m_valid = 1'b0; m_wait_imm = 1'b0; m_pend = '0;
    end else if (flush) begin
      m_valid = 1'b0; m_wait_imm = 1'b0;
    end else begin
      m_acc = in_valid && (!m_valid || dec_ready);
      if (m_valid && dec_ready) m_valid = 1'b0;
      if (m_acc) begin
        if (m_wait_imm) begin
          m_out = model_decode(m_pend, in_word, 1'b1);
          m_valid = 1'b1; m_wait_imm = 1'b0;
        end else if (in_word >= 16'h8000) begin
          m_pend = in_word; m_wait_imm = 1'b1;
        end else begin
          m_out = model_decode(in_word, 16'h0, 1'b0);
          m_valid = 1'b1;
        end
      end
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", {dec_valid, act}, '0);
    end else begin
      chk("in_ready", in_ready, !flush && (!m_valid || dec_ready));
      chk("dec_valid", dec_valid, m_valid);
      if (m_valid) chk("fields", act, m_out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w);
    in_word = w; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  logic [15:0] tbl [10];
  int          idx;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; dec_ready = 1'b1; in_word = '0;
    repeat (2) tick();
    chk("rst_dec_valid", dec_valid, 1'b0);
    chk("rst_len", insn_len, 2'd0);
    chk("rst_alu", alu_control, 8'h00);
    rst_n = 1'b1;
    tick();

    send({ADD, 8'h2B});
    chk("add_valid", dec_valid, 1'b1);
    chk("add_alu", alu_control, 8'h01);
    chk("add_rd", rD_sel, 3'd3);
    chk("add_rs", rS_sel, 3'd5);
    chk("add_en_imm", en_immediate, 1'b0);
    chk("add_len", insn_len, 2'd1);

    send({MOVB_R4, 8'hA5});
    chk("movb_rd", rD_sel, 3'd4);
    chk("movb_imm", immediate, 16'h00A5);
    chk("movb_en_imm", en_immediate, 1'b1);
    chk("movb_alu", alu_control, 8'h06);
    chk("movb_len", insn_len, 2'd1);

    send({8'h81, 8'h2B});
    chk("two_word_first_no_valid", dec_valid, 1'b0);
    send(16'h1234);
    chk("two_word_valid", dec_valid, 1'b1);
    chk("two_word_imm", immediate, 16'h1234);
    chk("two_word_en_imm", en_immediate, 1'b1);
    chk("two_word_rd", rD_sel, 3'd3);
    chk("two_word_rs", rS_sel, 3'd5);
    chk("two_word_len", insn_len, 2'd2);

    // Backpressure: result held while consumer stalls
    send({SUB, 8'h11});
    dec_ready = 1'b0;
    in_word = {XOR, 8'h3A}; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_alu", alu_control, 8'h02);
      chk("stall_rd", rD_sel, 3'd1);
    end
    dec_ready = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("after_stall_alu", alu_control, 8'h05);
    chk("after_stall_rd", rD_sel, 3'd2);
    chk("after_stall_rs", rS_sel, 3'd7);

    // Flush while waiting for an immediate; a word offered during flush is refused
    send({8'h85, 8'h00});
    flush = 1'b1; in_word = {ADD, 8'h2B}; in_valid = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("flush_valid", dec_valid, 1'b1);
    chk("flush_rd", rD_sel, 3'd3);
    chk("flush_en_imm", en_immediate, 1'b0);
    chk("flush_len", insn_len, 2'd1);

    send({LDI, 8'hC5});
    chk("ldi_mem", {en_mem, mem_byte, mem_displacement}, 3'b111);
    chk("ldi_rd", rD_sel, 3'd5);
    send({JMP, 8'h78});
    chk("jmp_cond", condition, 4'hF);
    chk("jmp_mem", en_mem, 1'b0);
    send({SPEC, 8'h00});
    chk("spec_lr", lr_is_input, 1'b1);

    // Asynchronous reset while waiting for an immediate
    send({ADD, 8'h2B});
    send({8'h95, 8'h07});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", dec_valid, 1'b0);
    chk("async_rst_alu", alu_control, 8'h00);
    chk("async_rst_rd", rD_sel, 3'd0);
    chk("async_rst_len", insn_len, 2'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send({PUSH, 8'h81});
    chk("push_valid", dec_valid, 1'b1);
    chk("push_rs", rS_sel, 3'd7);
    chk("push_mem", {en_mem, mem_byte}, 2'b11);
    chk("push_rd", rD_sel, 3'd1);
    chk("push_len", insn_len, 2'd1);

    // Streaming with intermittent consumer stalls
    tbl = '{{ADD, 8'h0A}, {ST, 8'h93}, {8'hA1, 8'h28}, 16'hBEEF, {POP, 8'h06},
            {8'hBB, 8'hFF}, 16'h5A5A, {CALL, 8'h50}, {STI, 8'h47}, {CALLI, 8'h18}};
    idx = 0;
    for (int c = 0; c < 80 && idx < 10; c++) begin
      in_word = tbl[idx]; in_valid = 1'b1; dec_ready = (c % 3) != 2;
      #1;
      if (in_ready) idx++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; dec_ready = 1'b1;
    chk("stream_done", 64'(idx), 64'd10);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
